buck_pwm_modulator: RTL and testbench

//   Timing master and gate-drive back end of the two-channel interleaved buck discharge stage.

---
 rtl/buck_pwm_modulator.sv | 131 +++++++++++++
 tb/tb_buck_pwm_modulator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/buck_pwm_modulator.sv
// Two-channel interleaved buck PWM modulator: 4us timebase master, on-time sampling/clamping,
// dead-time gate generation and synchronised over-current shutdown.
module buck_pwm_modulator #(
  parameter logic [15:0] PERIOD       = 16'd400,
  parameter logic [15:0] PHASE_OFFSET = 16'd200,
  parameter logic [15:0] MAX_ON       = 16'd180,
  parameter logic [15:0] DEAD_TIME    = 16'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fault_n,
  input  logic        fault_clear,
  input  logic [15:0] inductor_charging_time,
  output logic [15:0] timer_buck_4us_0,
  output logic [15:0] timer_buck_4us_1,
  output logic [1:0]  gate_h,
  output logic [1:0]  gate_l,
  output logic        fault_flag,
  output logic [1:0]  pwm_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [1:0][15:0] timer_q, timer_d;
  logic [1:0][15:0] on_q, on_d;
  logic [1:0]       state_q, state_d;
  logic [1:0]       gate_h_q, gate_h_d;
  logic [1:0]       gate_l_q, gate_l_d;
  logic             fs_meta_q, fs_q;

  function automatic logic [15:0] clamp_on(input logic [15:0] req);
    clamp_on = (req > MAX_ON) ? MAX_ON : req;
  endfunction

  function automatic logic [15:0] next_timer(input logic [15:0] t);
    next_timer = (t == PERIOD - 16'd1) ? 16'd0 : t + 16'd1;
  endfunction

  function automatic logic high_on(input logic [15:0] t, input logic [15:0] on);
    high_on = (on != 16'd0) && (t < on);
  endfunction

  // Zero on-time keeps the rectifier off too: diode emulation, no reverse inductor current.
  function automatic logic low_on(input logic [15:0] t, input logic [15:0] on);
    low_on = (on != 16'd0)
          && ({1'b0, t} >= ({1'b0, on} + {1'b0, DEAD_TIME}))
          && (t <= PERIOD - DEAD_TIME - 16'd1);
  endfunction

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      timer_d[n] = next_timer(timer_q[n]);
      on_d[n]    = on_q[n];
      if (timer_q[n] == PERIOD - 16'd1) begin
        on_d[n] = clamp_on(inductor_charging_time);
      end else begin
        on_d[n] = on_q[n];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (!fs_q) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = enable ? ST_ARM : ST_IDLE;
        ST_ARM: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (timer_q[0] == PERIOD - 16'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ARM;
          end
        end
        ST_RUN:   state_d = enable ? ST_RUN : ST_IDLE;
        ST_FAULT: state_d = fault_clear ? ST_IDLE : ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Gates are evaluated against next-cycle timer/on-time so the registered outputs line up with the displayed timers.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      gate_h_d[n] = (state_d == ST_RUN) && high_on(timer_d[n], on_d[n]);
      gate_l_d[n] = (state_d == ST_RUN) && low_on(timer_d[n], on_d[n]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_meta_q <= 1'b1;
      fs_q      <= 1'b1;
    end else begin
      fs_meta_q <= fault_n;
      fs_q      <= fs_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q[0] <= 16'd0;
      timer_q[1] <= PHASE_OFFSET;
      on_q       <= '0;
      state_q    <= ST_IDLE;
      gate_h_q   <= 2'b00;
      gate_l_q   <= 2'b00;
    end else begin
      timer_q  <= timer_d;
      on_q     <= on_d;
      state_q  <= state_d;
      gate_h_q <= gate_h_d;
      gate_l_q <= gate_l_d;
    end
  end

  assign timer_buck_4us_0 = timer_q[0];
  assign timer_buck_4us_1 = timer_q[1];
  assign gate_h           = gate_h_q;
  assign gate_l           = gate_l_q;
  assign pwm_state        = state_q;
  assign fault_flag       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_buck_pwm_modulator.sv
// Bench for buck_pwm_modulator: cycle-count reference model compared every cycle, plus
// hand-computed pulse-width / edge-position expectations and async reset checks.
module tb_buck_pwm_modulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fault_n = 1'b1;
  logic        fault_clear = 1'b0;
  logic [15:0] ict = 16'd0;
  logic [15:0] timer0, timer1;
  logic [1:0]  gate_h, gate_l, pwm_state;
  logic        fault_flag;

  int checks = 0;
  int errors = 0;

  buck_pwm_modulator dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fault_n(fault_n), .fault_clear(fault_clear),
    .inductor_charging_time(ict), .timer_buck_4us_0(timer0), .timer_buck_4us_1(timer1),
    .gate_h(gate_h), .gate_l(gate_l), .fault_flag(fault_flag), .pwm_state(pwm_state)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset release, per-channel on-time, mode.
  int tick;
  int on_m[2];
  int st_m;
  bit f1_m, fs_m;

  function automatic int clamp(input int v);
    return (v > 180) ? 180 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick = 0; on_m[0] = 0; on_m[1] = 0; st_m = 0; f1_m = 1'b1; fs_m = 1'b1;
    end else begin
      if (!fs_m) st_m = 3;
      else if (st_m == 0) st_m = enable ? 1 : 0;
      else if (st_m == 1) st_m = !enable ? 0 : ((tick % 400 == 399) ? 2 : 1);
      else if (st_m == 2) st_m = enable ? 2 : 0;
      else st_m = fault_clear ? 0 : 3;
      if (tick % 400 == 399) on_m[0] = clamp(int'(ict));
      if ((tick + 200) % 400 == 399) on_m[1] = clamp(int'(ict));
      fs_m = f1_m;
      f1_m = fault_n;
      tick++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      int t[2];
      int eh, el;
      t[0] = tick % 400;
      t[1] = (tick + 200) % 400;
      eh = 0; el = 0;
      for (int n = 0; n < 2; n++) begin
        if (st_m == 2 && on_m[n] != 0 && t[n] < on_m[n]) eh |= (1 << n);
        if (st_m == 2 && on_m[n] != 0 && t[n] >= on_m[n] + 10 && t[n] <= 389) el |= (1 << n);
      end
      chk("timer0", int'(timer0), t[0]);
      chk("timer1", int'(timer1), t[1]);
      chk("gate_h", int'(gate_h), eh);
      chk("gate_l", int'(gate_l), el);
      chk("pwm_state", int'(pwm_state), st_m);
      chk("fault_flag", int'(fault_flag), (st_m == 3) ? 1 : 0);
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_t0(input int val, input bit need_run, input string name);
    int budget = 1300;
    @(negedge clk);
    while (!(int'(timer0) == val && (!need_run || pwm_state == 2'd2)) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL wait_%s timed out timer0=%0d state=%0d", name, timer0, pwm_state);
    end
  endtask

  // Counts one full period of channel n starting at the current negedge (timer0 must be 0).
  task automatic measure(input int n, output int nh, output int nl, output int first_l, output int last_l);
    nh = 0; nl = 0; first_l = -1; last_l = -1;
    for (int i = 0; i < 400; i++) begin
      if (gate_h[n]) nh++;
      if (gate_l[n]) begin
        nl++;
        if (first_l < 0) first_l = int'(timer0);
        last_l = int'(timer0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int nh, nl, fl, ll;
    cycles(3);
    chk("rst_timer0", int'(timer0), 0);
    chk("rst_timer1", int'(timer1), 200);
    chk("rst_state", int'(pwm_state), 0);
    rst_n = 1'b1;

    // 1: idle counting and wrap
    ict = 16'd77;
    cycles(450);
    chk("idle_state", int'(pwm_state), 0);

    // 2: steady 100-clock request
    ict = 16'd100;
    enable = 1'b1;
    wait_t0(0, 1'b1, "run100");
    chk("run_at_t0", int'(pwm_state), 2);
    measure(0, nh, nl, fl, ll);
    chk("h100_width", nh, 100);
    chk("l100_width", nl, 280);
    chk("l100_first", fl, 110);
    chk("l100_last", ll, 389);
    measure(1, nh, nl, fl, ll);
    chk("ch1_h100_width", nh, 100);
    chk("ch1_l100_width", nl, 280);

    // 3: clamp and zero request
    ict = 16'd250;
    wait_t0(0, 1'b1, "clamp");
    measure(0, nh, nl, fl, ll);
    chk("h250_width", nh, 180);
    chk("l250_first", fl, 190);
    ict = 16'd0;
    wait_t0(0, 1'b1, "zero");
    measure(0, nh, nl, fl, ll);
    chk("h0_width", nh, 0);
    chk("l0_width", nl, 0);

    // 4: mid-period change only takes effect at the next latch point
    ict = 16'd100;
    wait_t0(0, 1'b1, "chg_a");
    wait_t0(50, 1'b1, "chg_b");
    ict = 16'd60;
    nh = 0;
    for (int i = 50; i < 400; i++) begin
      if (gate_h[0]) nh++;
      @(negedge clk);
    end
    chk("cur_pulse_kept", nh + 50, 100);
    measure(0, nh, nl, fl, ll);
    chk("next_pulse_60", nh, 60);

    // 5: fault mid-pulse, clear ignored while active, then recovery
    ict = 16'd100;
    wait_t0(30, 1'b1, "fault");
    fault_n = 1'b0;
    cycles(3);
    chk("fault_gate_h", int'(gate_h), 0);
    chk("fault_gate_l", int'(gate_l), 0);
    chk("fault_flag_set", int'(fault_flag), 1);
    fault_clear = 1'b1;
    cycles(1);
    fault_clear = 1'b0;
    cycles(2);
    chk("clear_ignored", int'(pwm_state), 3);
    fault_n = 1'b1;
    cycles(4);
    chk("still_fault", int'(pwm_state), 3);
    fault_clear = 1'b1;
    cycles(1);
    fault_clear = 1'b0;
    chk("cleared_idle", int'(pwm_state), 0);
    cycles(1);
    chk("rearm", int'(pwm_state), 1);
    wait_t0(0, 1'b1, "rerun");
    chk("rerun_t0", int'(timer0), 0);

    // 6: asynchronous reset mid-pulse
    wait_t0(40, 1'b1, "rst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gate_h", int'(gate_h), 0);
    chk("arst_gate_l", int'(gate_l), 0);
    chk("arst_timer0", int'(timer0), 0);
    chk("arst_timer1", int'(timer1), 200);
    chk("arst_state", int'(pwm_state), 0);
    cycles(2);
    rst_n = 1'b1;

    // Random traffic: requests, enable drops, fault glitches, stray clears
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) ict = 16'($urandom_range(0, 300));
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 49) == 0) enable = 1'b1;
      fault_n = ($urandom_range(0, 799) == 0) ? 1'b0 : (fault_n & ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b1);
      fault_clear = ($urandom_range(0, 39) == 0);
    end
    fault_n = 1'b1;
    fault_clear = 1'b0;
    cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
